// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg: shared front-end types and constants for the multicycle core.
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int INST_WIDTH   = 32;
  localparam int PC_INCREMENT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pc_gen: combinational next-PC select (hold / +4 / redirect) with
// target alignment; FETCH_MISALIGN_EN keeps misaligned targets and flags them.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_inc,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic [ADDR_WIDTH-1:0] o_next_pc,
  output logic                  o_misaligned
);

  logic [ADDR_WIDTH-1:0] w_target;

`ifdef FETCH_MISALIGN_EN
  assign w_target = i_redirect_pc;
`else
  assign w_target = i_redirect_pc & ~ADDR_WIDTH'(3);
`endif

  // Redirect wins over increment; the add wraps at 2^ADDR_WIDTH.
  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect) begin
      o_next_pc = w_target;
    end else if (i_inc) begin
      o_next_pc = i_pc + ADDR_WIDTH'(PC_INCREMENT);
    end
  end

`ifdef FETCH_MISALIGN_EN
  assign o_misaligned = |o_next_pc[1:0];
`else
  assign o_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage: owns the PC, keeps one instruction-memory read in flight and
// presents {inst, pc} over valid/ready. Option: FETCH_MISALIGN_EN (o_fault).
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                  o_fault
`endif
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_squash;
  logic                  w_squash_next;
  logic                  w_inc;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_misaligned;
  logic                  w_fault_launch;

  assign w_inc = (r_state == S_HOLD) && i_ready && !i_redirect;

  fetch_pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_gen (
    .i_pc          (r_pc),
    .i_inc         (w_inc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_next_pc     (w_next_pc),
    .o_misaligned  (w_misaligned)
  );

  // w_launch marks every point where a fresh request would start at w_next_pc.
  always_comb begin
    w_state_next   = r_state;
    w_squash_next  = r_squash;
    w_launch       = 1'b0;
    w_capture      = 1'b0;
    w_fault_launch = 1'b0;
    unique case (r_state)
      S_IDLE: w_launch = 1'b1;
      S_FETCH: begin
        if (i_mem_ack) begin
          if (i_redirect || r_squash) begin
            w_launch      = 1'b1;
            w_squash_next = 1'b0;
          end else begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
          end
        end else if (i_redirect) begin
          w_squash_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_redirect || i_ready) begin
          w_launch = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Only a redirect target can be misaligned; pc+4 from a faulted pc is fetched.
    if (w_launch) begin
      w_fault_launch = w_misaligned && (i_redirect || r_squash);
      w_state_next   = w_fault_launch ? S_HOLD : S_FETCH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_squash   <= 1'b0;
      r_inst     <= '0;
      r_out_pc   <= RESET_PC;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_next_pc;
      r_squash <= w_squash_next;
      if (w_launch && !w_fault_launch) begin
        r_mem_addr <= w_next_pc;
      end
      if (w_capture) begin
        r_inst   <= i_mem_rdata;
        r_out_pc <= r_pc;
      end
      if (w_fault_launch) begin
        r_inst   <= '0;
        r_out_pc <= w_next_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic r_fault;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fault <= 1'b0;
    end else if (w_launch) begin
      r_fault <= w_fault_launch;
    end
  end

  assign o_fault = r_fault;
`endif

  assign o_mem_req  = (r_state == S_FETCH);
  assign o_mem_addr = r_mem_addr;
  assign o_valid    = (r_state == S_HOLD);
  assign o_inst     = r_inst;
  assign o_pc       = r_out_pc;

endmodule
`default_nettype wire
